array_scan_ctrl: RTL and testbench
==================================

# array_scan_ctrl

Sequencer that drives the 8-bit address register and memory read port to scan a block of unsigned data words, producing MAX, MIN, SUM and floor-average results for the MAX/MIN/AVG ASIP. It loads the address register with a base address, steps it once per element, samples memory data and accumulates the results. It then runs a sequential divider for the average and signals completion with a one-cycle DONE pulse. It sits between the instruction decoder (START/BASE/COUNT) and the address-register/memory datapath.

## Interface
- DW, 8, data word width (unsigned)
- AW, 8, address and count width
- SW, DW+AW, sum accumulator width (no overflow for COUNT ≤ 2^AW−1)
- CLK  in  1  clock, all state on rising edge
- RESET  in  1  synchronous, active-high reset
- START  in  1  begin scan; sampled only in IDLE
- BASE  in  AW  first element address, captured with START
- COUNT  in  AW  number of elements, captured with START
- MEM_DATA  in  DW  memory word at current address register value (combinational read, valid same cycle)
- AR_IN  out  AW  load value for address register (= captured BASE)
- AR_LOAD  out  1  load address register
- AR_INC  out  1  increment address register
- BUSY  out  1  high in every state except IDLE
- DONE  out  1  one-cycle completion pulse
- ERR  out  1  COUNT was 0 on last START; held until next START
- MAX_OUT, MIN_OUT  out  DW  extreme values of the scanned block
- SUM_OUT  out  SW  sum of scanned block
- AVG_OUT  out  DW  floor(SUM/COUNT)

## Operation
- States: IDLE, SCAN, DIV, FIN.
- IDLE: when START=1, capture BASE/COUNT and clear SUM and ERR. If COUNT≠0, assert AR_LOAD (Mealy, same cycle) with AR_IN=BASE and go to SCAN. If COUNT=0, set ERR, zero all results and go to FIN.
- SCAN: one element per cycle; element index k=0..COUNT−1.
  - k=0: MAX=MIN=MEM_DATA, SUM=MEM_DATA.
  - k>0: MAX=max(MAX,MEM_DATA), MIN=min(MIN,MEM_DATA), SUM+=MEM_DATA (zero-extended).
  - AR_INC=1 on every SCAN cycle except the last.
  - After the last element go to DIV, or to FIN if the average is compiled out.
- DIV: restoring shift-subtract divide SUM/COUNT over SW cycles. The low DW bits of the quotient go to AVG_OUT; the quotient never exceeds 2^DW−1. Then go to FIN.
- FIN: DONE=1 for one cycle, then go to IDLE.
- START while BUSY is ignored, with no effect on captured operands.
- Results hold from DONE until the next accepted START.
- AR_LOAD and AR_INC are never asserted together, and both are 0 outside the cycles listed above.
- Address wrap (0xFF→0x00) is the address register's natural behaviour. The controller neither detects nor blocks it.

## Timing
- RESET: state=IDLE; BUSY, DONE, ERR, AR_LOAD, AR_INC=0; AR_IN, MAX_OUT, MIN_OUT, SUM_OUT, AVG_OUT=0. RESET wins over START in the same cycle.
- RESET mid-scan or mid-divide aborts immediately: no DONE pulse, results zeroed. The next scan requires a fresh START.
- START accepted at cycle t: AR_LOAD=1 at t; BUSY=1 from t+1.
- Element k is sampled at t+1+k.
- DONE timing: at t+COUNT+1+SW with average compiled in, at t+COUNT+1 without it, and at t+1 for COUNT=0.
- A new START is accepted at the earliest one cycle after DONE.

## Configuration
- SCAN_AVG_EN defined: DIV state and divider are present, and AVG_OUT=floor(SUM/COUNT).
- SCAN_AVG_EN undefined: no DIV state and no divider. SCAN goes directly to FIN, and AVG_OUT is tied to 0.

## Structure
- Shared package: state enum (IDLE, SCAN, DIV, FIN), DW/AW/SW default constants.
- Sub-module seq_divider handles the SW-cycle restoring unsigned divide. Its handshake is start pulse in, done pulse out, with quotient and remainder outputs. It is instantiated only under SCAN_AVG_EN.

## Test plan
- BASE=0x10, COUNT=4, memory {5,200,17,9} → MAX=200, MIN=5, SUM=231, AVG=57. AR_LOAD at t, AR_INC at t+1..t+3, DONE at t+21 (SCAN_AVG_EN defined) or t+5 (undefined).
- COUNT=0 → ERR=1, no AR_LOAD/AR_INC, all results 0, DONE at t+1.
- BASE=0xFE, COUNT=3, memory {0xFE:1, 0xFF:2, 0x00:3} → wrap is transparent: MAX=3, MIN=1, SUM=6, AVG=2.
- COUNT=255, all words 0xFF → SUM=0xFE01, AVG=0xFF, with no overflow.
- START pulsed again mid-SCAN with different BASE/COUNT → ignored; results match the first operands.
- RESET asserted during DIV → next cycle is IDLE with all outputs 0, no DONE. A following START with COUNT=1, word 42 gives MAX=MIN=SUM=AVG=42.

Source files
------------

// File: rtl/array_scan_ctrl_pkg.sv
// array_scan_ctrl_pkg
// Shared definitions for the MAX/MIN/AVG scan controller slice.
//   DW : data word width (unsigned)
//   AW : address / element count width
//   SW : sum accumulator width, wide enough for 255 words of 0xFF
//   scan_state_t : controller state encoding (IDLE, SCAN, DIV, FIN)
package array_scan_ctrl_pkg;

    localparam int DW = 8;
    localparam int AW = 8;
    localparam int SW = DW + AW;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DIV  = 2'd2,
        FIN  = 2'd3
    } scan_state_t;

endpackage

// File: rtl/array_scan_ctrl_if.sv
// array_scan_ctrl_if
// Bundles the decoder handshake, the memory read data, the address register
// controls and the result bus of the scan controller.
//   master : decoder / datapath side (drives START, BASE, COUNT, MEM_DATA)
//   slave  : the controller (drives AR_*, BUSY, DONE, ERR and the results)
interface array_scan_ctrl_if;
    import array_scan_ctrl_pkg::*;

    logic          START;
    logic [AW-1:0] BASE;
    logic [AW-1:0] COUNT;
    logic [DW-1:0] MEM_DATA;
    logic [AW-1:0] AR_IN;
    logic          AR_LOAD;
    logic          AR_INC;
    logic          BUSY;
    logic          DONE;
    logic          ERR;
    logic [DW-1:0] MAX_OUT;
    logic [DW-1:0] MIN_OUT;
    logic [SW-1:0] SUM_OUT;
    logic [DW-1:0] AVG_OUT;

    modport master (
        output START, BASE, COUNT, MEM_DATA,
        input  AR_IN, AR_LOAD, AR_INC, BUSY, DONE, ERR,
               MAX_OUT, MIN_OUT, SUM_OUT, AVG_OUT
    );

    modport slave (
        input  START, BASE, COUNT, MEM_DATA,
        output AR_IN, AR_LOAD, AR_INC, BUSY, DONE, ERR,
               MAX_OUT, MIN_OUT, SUM_OUT, AVG_OUT
    );

endinterface

// File: rtl/array_scan_ctrl_seq_divider.sv
// seq_divider
// Restoring shift-subtract unsigned divider, one quotient bit per clock.
// A start pulse loads the operands; NW iterations follow. done is high
// during the final iteration cycle, and quotient/remainder present the
// final result in that same cycle so the caller can capture it at the edge.
//   CLK, RESET : clock, synchronous active-high reset
//   start      : load dividend/divisor and begin
//   dividend   : NW-bit dividend
//   divisor    : VW-bit divisor (non-zero)
//   done       : one-cycle pulse, result valid
//   quotient   : low QW bits of the quotient
//   remainder  : VW-bit remainder
module seq_divider #(
    parameter int NW = 16,
    parameter int VW = 8,
    parameter int QW = 8
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          start,
    input  logic [NW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          done,
    output logic [QW-1:0] quotient,
    output logic [VW-1:0] remainder
);
    localparam int CW = $clog2(NW + 1);

    logic [NW-1:0] quo_q, quo_n;
    logic [VW-1:0] rem_q, rem_n, dvs_q;
    logic [VW:0]   rem_sh;
    logic [CW-1:0] cnt_q;
    logic          busy_q;

    // One restoring step: shift the next dividend bit into the partial
    // remainder and subtract the divisor when it fits. The remainder always
    // stays below the divisor, so VW bits are enough to hold it.
    always_comb begin
        rem_sh = {rem_q, quo_q[NW-1]};
        rem_n  = rem_sh[VW-1:0];
        quo_n  = {quo_q[NW-2:0], 1'b0};
        if (rem_sh >= {1'b0, dvs_q}) begin
            rem_n  = rem_sh[VW-1:0] - dvs_q;
            quo_n  = {quo_q[NW-2:0], 1'b1};
        end
    end

    // Operand capture and the NW iteration steps.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            quo_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start) begin
            quo_q  <= dividend;
            rem_q  <= '0;
            dvs_q  <= divisor;
            cnt_q  <= CW'(NW);
            busy_q <= 1'b1;
        end else if (busy_q) begin
            quo_q <= quo_n;
            rem_q <= rem_n;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign done      = busy_q && (cnt_q == CW'(1));
    assign quotient  = quo_n[QW-1:0];
    assign remainder = rem_n;

endmodule

// File: rtl/array_scan_ctrl.sv
// array_scan_ctrl
// Sequencer for the MAX/MIN/AVG ASIP: loads the address register with BASE,
// steps it once per element, accumulates MAX/MIN/SUM from MEM_DATA and, when
// built with SCAN_AVG_EN, runs a sequential divide for floor(SUM/COUNT).
// Completion is flagged with a one-cycle DONE pulse.
//   CLK, RESET : clock, synchronous active-high reset
//   bus.START/BASE/COUNT : scan request from the decoder (used in IDLE only)
//   bus.MEM_DATA          : word at the current address register value
//   bus.AR_IN/AR_LOAD/AR_INC : address register load value and controls
//   bus.BUSY/DONE/ERR     : status (ERR = last accepted COUNT was zero)
//   bus.MAX_OUT/MIN_OUT/SUM_OUT/AVG_OUT : results, held until next START
// Build option: SCAN_AVG_EN adds the DIV state and divider; without it
// AVG_OUT is tied to zero.
module array_scan_ctrl
    import array_scan_ctrl_pkg::*;
(
    input logic              CLK,
    input logic              RESET,
    array_scan_ctrl_if.slave bus
);
    scan_state_t   state_q, state_d;
    logic [AW-1:0] base_q, count_q, idx_q;
    logic [DW-1:0] max_q, min_q, max_d, min_d;
    logic [SW-1:0] sum_q, sum_d, mem_ext;
    logic          err_q;
    logic          start_ok;
    logic          last_elem;

`ifdef SCAN_AVG_EN
    logic [DW-1:0] avg_q;
    logic [DW-1:0] div_quo;
    logic [AW-1:0] div_rem_unused;
    logic          div_start;
    logic          div_done;
`endif

    // RESET takes priority over a simultaneous START.
    assign start_ok  = (state_q == IDLE) && bus.START && !RESET;
    assign last_elem = (idx_q == count_q - AW'(1));

    // Running results including the word on MEM_DATA this cycle. Element 0
    // seeds all three accumulators instead of combining with stale values.
    always_comb begin
        mem_ext = SW'(bus.MEM_DATA);
        sum_d   = sum_q + mem_ext;
        max_d   = (bus.MEM_DATA > max_q) ? bus.MEM_DATA : max_q;
        min_d   = (bus.MEM_DATA < min_q) ? bus.MEM_DATA : min_q;
        if (idx_q == '0) begin
            sum_d = mem_ext;
            max_d = bus.MEM_DATA;
            min_d = bus.MEM_DATA;
        end
    end

`ifdef SCAN_AVG_EN
    // The divide is launched during the last SCAN cycle with the final sum
    // taken combinationally, so DIV lasts exactly SW cycles.
    assign div_start = (state_q == SCAN) && last_elem;

    seq_divider #(
        .NW(SW),
        .VW(AW),
        .QW(DW)
    ) u_div (
        .CLK      (CLK),
        .RESET    (RESET),
        .start    (div_start),
        .dividend (sum_d),
        .divisor  (count_q),
        .done     (div_done),
        .quotient (div_quo),
        .remainder(div_rem_unused)
    );
`endif

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. A zero COUNT skips straight to FIN so DONE still
    // arrives one cycle after START.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d = (bus.COUNT == '0) ? FIN : SCAN;
                end
            end
            SCAN: begin
                if (last_elem) begin
`ifdef SCAN_AVG_EN
                    state_d = DIV;
`else
                    state_d = FIN;
`endif
                end
            end
`ifdef SCAN_AVG_EN
            DIV: begin
                if (div_done) begin
                    state_d = FIN;
                end
            end
`endif
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand capture and result accumulation. Results are only touched by
    // an accepted START or by the scan itself, so they hold after DONE.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            base_q  <= '0;
            count_q <= '0;
            idx_q   <= '0;
            max_q   <= '0;
            min_q   <= '0;
            sum_q   <= '0;
            err_q   <= 1'b0;
`ifdef SCAN_AVG_EN
            avg_q   <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        base_q  <= bus.BASE;
                        count_q <= bus.COUNT;
                        idx_q   <= '0;
                        sum_q   <= '0;
                        err_q   <= (bus.COUNT == '0);
                        if (bus.COUNT == '0) begin
                            max_q <= '0;
                            min_q <= '0;
`ifdef SCAN_AVG_EN
                            avg_q <= '0;
`endif
                        end
                    end
                end
                SCAN: begin
                    idx_q <= idx_q + AW'(1);
                    sum_q <= sum_d;
                    max_q <= max_d;
                    min_q <= min_d;
                end
`ifdef SCAN_AVG_EN
                DIV: begin
                    if (div_done) begin
                        avg_q <= div_quo;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    // AR_LOAD is a Mealy output in the accepting cycle, so AR_IN must show
    // BASE directly in that cycle rather than the previously captured value.
    assign bus.AR_IN   = start_ok ? bus.BASE : base_q;
    assign bus.AR_LOAD = start_ok && (bus.COUNT != '0);
    assign bus.AR_INC  = (state_q == SCAN) && !last_elem;
    assign bus.BUSY    = (state_q != IDLE);
    assign bus.DONE    = (state_q == FIN);
    assign bus.ERR     = err_q;
    assign bus.MAX_OUT = max_q;
    assign bus.MIN_OUT = min_q;
    assign bus.SUM_OUT = sum_q;
`ifdef SCAN_AVG_EN
    assign bus.AVG_OUT = avg_q;
`else
    assign bus.AVG_OUT = '0;
`endif

endmodule

// File: tb/tb_array_scan_ctrl.sv
// tb_array_scan_ctrl
// Self-checking bench for array_scan_ctrl. A behavioural address register
// and a 256-word memory surround the controller. Expected results come from
// a fixed vector table and from a reference function that walks the memory
// block with plain integer arithmetic. Honours SCAN_AVG_EN for AVG_OUT and
// DONE latency.
`timescale 1ns/1ps
module tb_array_scan_ctrl;
    import array_scan_ctrl_pkg::*;

`ifdef SCAN_AVG_EN
    localparam int DIV_LAT = SW;
    localparam bit AVG_EN  = 1'b1;
`else
    localparam int DIV_LAT = 0;
    localparam bit AVG_EN  = 1'b0;
`endif

    typedef struct {
        logic [7:0]      base;
        logic [7:0]      count;
        logic [3:0][7:0] words;
        logic [7:0]      exp_max;
        logic [7:0]      exp_min;
        logic [15:0]     exp_sum;
        logic [7:0]      exp_avg;
        logic            exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    array_scan_ctrl_if bus_if();

    array_scan_ctrl dut (
        .CLK  (clk),
        .RESET(reset),
        .bus  (bus_if)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [256];
    logic [7:0] ar;
    int cyc;
    int load_cnt, load_cyc, inc_cnt, both_cnt, done_cnt, done_cyc;
    int tests_run, tests_failed;
    vec_t vecs [5];

    assign bus_if.MEM_DATA = mem[ar];

    // Address register the controller drives, plus a cycle counter.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus_if.AR_LOAD) ar <= bus_if.AR_IN;
        else if (bus_if.AR_INC) ar <= ar + 8'd1;
    end

    // Event monitor sampled mid-cycle.
    always @(negedge clk) begin
        if (bus_if.AR_LOAD) begin
            load_cnt++;
            load_cyc = cyc;
        end
        if (bus_if.AR_INC) inc_cnt++;
        if (bus_if.AR_LOAD && bus_if.AR_INC) both_cnt++;
        if (bus_if.DONE) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic clearMon();
        load_cnt = 0;
        inc_cnt  = 0;
        both_cnt = 0;
        done_cnt = 0;
        load_cyc = -1;
        done_cyc = -1;
    endtask

    // Reference: walk the block in memory with integer arithmetic.
    function automatic void refModel(input logic [7:0] base, input logic [7:0] count,
                                     output logic [7:0] mx, output logic [7:0] mn,
                                     output logic [15:0] sm, output logic [7:0] av,
                                     output logic er);
        int s, hi, lo, w;
        s = 0; hi = 0; lo = 255;
        if (count == 8'd0) begin
            mx = 0; mn = 0; sm = 0; av = 0; er = 1'b1;
            return;
        end
        for (int i = 0; i < int'(count); i++) begin
            w = int'(mem[8'(int'(base) + i)]);
            s += w;
            if (w > hi) hi = w;
            if (w < lo) lo = w;
        end
        mx = 8'(hi);
        mn = 8'(lo);
        sm = 16'(s);
        av = 8'(s / int'(count));
        er = 1'b0;
    endfunction

    // Launch one scan, optionally poke START again mid-scan, wait for DONE.
    task automatic applyStimulus(input logic [7:0] base, input logic [7:0] count,
                                 input int mid_cycles, output int t, output bit timed_out);
        @(posedge clk); #1;
        clearMon();
        bus_if.START = 1'b1;
        bus_if.BASE  = base;
        bus_if.COUNT = count;
        t = cyc;
        @(posedge clk); #1;
        bus_if.START = 1'b0;
        bus_if.BASE  = 8'($urandom);
        bus_if.COUNT = 8'($urandom);
        if (mid_cycles > 0) begin
            repeat (mid_cycles) @(posedge clk);
            #1;
            bus_if.START = 1'b1;
            bus_if.BASE  = base ^ 8'h5A;
            bus_if.COUNT = count + 8'd3;
            @(posedge clk); #1;
            bus_if.START = 1'b0;
        end
        timed_out = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if (done_cnt > 0) begin
                timed_out = 1'b0;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic runAndCheck(input string name, input logic [7:0] base, input logic [7:0] count,
                               input int mid_cycles, input logic [7:0] e_max, input logic [7:0] e_min,
                               input logic [15:0] e_sum, input logic [7:0] e_avg, input logic e_err);
        int t;
        bit to;
        applyStimulus(base, count, mid_cycles, t, to);
        checkOutput({name, " timeout"}, 32'(to), 32'd0);
        if (!to) begin
            checkOutput({name, " done_lat"}, 32'(done_cyc - t),
                        (count == 8'd0) ? 32'd1 : 32'(int'(count) + 1 + DIV_LAT));
            @(negedge clk);
            checkOutput({name, " max"}, 32'(bus_if.MAX_OUT), 32'(e_max));
            checkOutput({name, " min"}, 32'(bus_if.MIN_OUT), 32'(e_min));
            checkOutput({name, " sum"}, 32'(bus_if.SUM_OUT), 32'(e_sum));
            checkOutput({name, " avg"}, 32'(bus_if.AVG_OUT), AVG_EN ? 32'(e_avg) : 32'd0);
            checkOutput({name, " err"}, 32'(bus_if.ERR), 32'(e_err));
            checkOutput({name, " ar_load_cnt"}, 32'(load_cnt), (count == 8'd0) ? 32'd0 : 32'd1);
            if (count != 8'd0) checkOutput({name, " ar_load_cyc"}, 32'(load_cyc - t), 32'd0);
            checkOutput({name, " ar_inc_cnt"}, 32'(inc_cnt), (count == 8'd0) ? 32'd0 : 32'(int'(count) - 1));
            checkOutput({name, " load_inc_overlap"}, 32'(both_cnt), 32'd0);
            repeat (2) @(posedge clk);
            #1;
            checkOutput({name, " done_pulses"}, 32'(done_cnt), 32'd1);
            checkOutput({name, " busy_after"}, 32'(bus_if.BUSY), 32'd0);
        end
    endtask

    initial begin
        int t;
        logic [7:0] b, c, emx, emn, eav;
        logic [15:0] esm;
        logic eer;

        foreach (mem[i]) mem[i] = 8'd0;
        clearMon();

        vecs[0] = '{8'h10, 8'd4, {8'd9, 8'd17, 8'd200, 8'd5}, 8'd200, 8'd5, 16'd231, 8'd57, 1'b0};
        vecs[1] = '{8'h33, 8'd0, {8'd7, 8'd7, 8'd7, 8'd7}, 8'd0, 8'd0, 16'd0, 8'd0, 1'b1};
        vecs[2] = '{8'hFE, 8'd3, {8'd0, 8'd3, 8'd2, 8'd1}, 8'd3, 8'd1, 16'd6, 8'd2, 1'b0};
        vecs[3] = '{8'h80, 8'd1, {8'd0, 8'd0, 8'd0, 8'd42}, 8'd42, 8'd42, 16'd42, 8'd42, 1'b0};
        vecs[4] = '{8'h40, 8'd2, {8'd0, 8'd0, 8'd255, 8'd0}, 8'd255, 8'd0, 16'd255, 8'd127, 1'b0};

        // Reset with START held: RESET must win.
        bus_if.START = 1'b1;
        bus_if.BASE  = 8'h55;
        bus_if.COUNT = 8'd3;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst ar_load", 32'(bus_if.AR_LOAD), 32'd0);
        checkOutput("rst ar_in", 32'(bus_if.AR_IN), 32'd0);
        checkOutput("rst busy", 32'(bus_if.BUSY), 32'd0);
        checkOutput("rst done", 32'(bus_if.DONE), 32'd0);
        checkOutput("rst err", 32'(bus_if.ERR), 32'd0);
        checkOutput("rst results", 32'({bus_if.MAX_OUT, bus_if.MIN_OUT} | bus_if.SUM_OUT | bus_if.AVG_OUT), 32'd0);
        bus_if.START = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("post_rst busy", 32'(bus_if.BUSY), 32'd0);

        // Table vectors.
        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < 4; i++) mem[8'(int'(vecs[v].base) + i)] = vecs[v].words[i];
            runAndCheck($sformatf("vec%0d", v), vecs[v].base, vecs[v].count, 0,
                        vecs[v].exp_max, vecs[v].exp_min, vecs[v].exp_sum, vecs[v].exp_avg, vecs[v].exp_err);
        end

        // Full-length block of 0xFF: widest sum, largest quotient.
        foreach (mem[i]) mem[i] = 8'hFF;
        runAndCheck("full255", 8'h00, 8'd255, 0, 8'hFF, 8'hFF, 16'hFE01, 8'hFF, 1'b0);

        // START re-pulsed during SCAN is ignored.
        for (int i = 0; i < 6; i++) mem[8'h20 + i] = 8'(10 * i + 3);
        runAndCheck("mid_start", 8'h20, 8'd6, 2, 8'd53, 8'd3, 16'd168, 8'd28, 1'b0);

        // Randomized blocks against the reference model.
        for (int r = 0; r < 16; r++) begin
            foreach (mem[i]) mem[i] = 8'($urandom);
            b = 8'($urandom);
            c = 8'($urandom_range(0, 24));
            refModel(b, c, emx, emn, esm, eav, eer);
            runAndCheck($sformatf("rand%0d", r), b, c, 0, emx, emn, esm, eav, eer);
        end

        // RESET in the middle of DIV (or SCAN when no divider) aborts.
        for (int i = 0; i < 8; i++) mem[8'h60 + i] = 8'(i + 1);
        @(posedge clk); #1;
        clearMon();
        bus_if.START = 1'b1;
        bus_if.BASE  = 8'h60;
        bus_if.COUNT = 8'd8;
        t = cyc;
        @(posedge clk); #1;
        bus_if.START = 1'b0;
        repeat (AVG_EN ? 11 : 3) @(posedge clk);
        #1;
        checkOutput("abort busy_before", 32'(bus_if.BUSY), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checkOutput("abort busy", 32'(bus_if.BUSY), 32'd0);
        checkOutput("abort done", 32'(bus_if.DONE), 32'd0);
        checkOutput("abort err", 32'(bus_if.ERR), 32'd0);
        checkOutput("abort ar_in", 32'(bus_if.AR_IN), 32'd0);
        checkOutput("abort results", 32'({bus_if.MAX_OUT, bus_if.MIN_OUT} | bus_if.SUM_OUT | bus_if.AVG_OUT), 32'd0);
        repeat (40) @(posedge clk);
        #1;
        checkOutput("abort no_done", 32'(done_cnt), 32'd0);
        mem[8'h70] = 8'd42;
        runAndCheck("after_abort", 8'h70, 8'd1, 0, 8'd42, 8'd42, 16'd42, 8'd42, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule
